// File: rtl/mxc_pkg.sv
// Shared parameters, reset defaults and config record for the
// multiplexed-counter pulse shaper.
package mxc_pkg;

   localparam int NCH = 8;
   localparam int WW  = 16;

   localparam logic [WW-1:0] WIDTH_RST = WW'(1);
   localparam logic          EN_RST    = 1'b0;
   localparam logic          POL_RST   = 1'b0;

   typedef struct packed {
      logic [WW-1:0] width;
      logic          en;
      logic          pol;
   } mxc_cfg_t;

   function automatic mxc_cfg_t cfg_rst();
      mxc_cfg_t c;
      c.width = WIDTH_RST;
      c.en    = EN_RST;
      c.pol   = POL_RST;
      return c;
   endfunction

endpackage

// File: rtl/mxc_pulse_shaper_if.sv
// Register-write bus carrying per-channel pulse configuration.
interface mxc_pulse_shaper_if;
   import mxc_pkg::*;

   logic          cfg_wr;
   logic [2:0]    cfg_sel;
   logic [WW-1:0] cfg_width;
   logic          cfg_en;
   logic          cfg_pol;

   modport master (
      output cfg_wr, cfg_sel, cfg_width, cfg_en, cfg_pol
   );

   modport slave (
      input cfg_wr, cfg_sel, cfg_width, cfg_en, cfg_pol
   );

endinterface

// File: rtl/mxc_pulse_chan.sv
// One shaper channel: edge detect, width counter, config,
// registered outputs and sticky edge flag.
module mxc_pulse_chan
   import mxc_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     i_mxc,
   input  logic     i_wr,
   input  mxc_cfg_t i_cfg,
   input  logic     i_clr,
   output logic     o_pulse,
   output logic     o_busy,
   output logic     o_seen
);

   mxc_cfg_t      r_cfg;
   logic          r_prev;
   logic [WW-1:0] r_cnt;
   logic          r_busy;
   logic          r_pulse;
   logic          r_seen;

   logic [WW-1:0] w_cnt_nxt;
   logic          w_edge;
   logic          w_fire;
   logic          w_pol_nxt;

   assign w_edge = i_mxc & ~r_prev;
   assign w_fire = w_edge & r_cfg.en & (r_cfg.width != '0);
   assign w_pol_nxt = i_wr ? i_cfg.pol : r_cfg.pol;

   // Disabling a channel truncates any pulse in progress.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (i_wr && !i_cfg.en)
         w_cnt_nxt = '0;
      else if (w_fire)
         w_cnt_nxt = r_cfg.width;
      else if (r_cnt != '0)
         w_cnt_nxt = r_cnt - WW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cfg   <= cfg_rst();
         r_prev  <= 1'b0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_pulse <= 1'b0;
         r_seen  <= 1'b0;
      end else begin
         if (i_wr)
            r_cfg <= i_cfg;
         r_prev  <= i_mxc;
         r_cnt   <= w_cnt_nxt;
         r_busy  <= (w_cnt_nxt != '0);
         r_pulse <= (w_cnt_nxt != '0) ^ w_pol_nxt;
         r_seen  <= w_edge | (r_seen & ~i_clr);
      end
   end

   assign o_pulse = r_pulse;
   assign o_busy  = r_busy;
   assign o_seen  = r_seen;

endmodule

// File: rtl/mxc_pulse_shaper.sv
// Shapes rising edges of the multiplexed-counter clock outputs
// into programmable-width, polarity-selectable trigger pulses.
module mxc_pulse_shaper
   import mxc_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NCH-1:0]     mxc_in,
   mxc_pulse_shaper_if.slave  cfg,
   input  logic [NCH-1:0]     clr_seen,
   output logic [NCH-1:0]     pulse_out,
   output logic [NCH-1:0]     busy,
   output logic [NCH-1:0]     edge_seen
);

   mxc_cfg_t       w_cfg;
   logic [NCH-1:0] w_wr;

   assign w_cfg.width = cfg.cfg_width;
   assign w_cfg.en    = cfg.cfg_en;
   assign w_cfg.pol   = cfg.cfg_pol;

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign w_wr[i] = cfg.cfg_wr && (cfg.cfg_sel == 3'(i));

      mxc_pulse_chan u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_mxc   (mxc_in[i]),
         .i_wr    (w_wr[i]),
         .i_cfg   (w_cfg),
         .i_clr   (clr_seen[i]),
         .o_pulse (pulse_out[i]),
         .o_busy  (busy[i]),
         .o_seen  (edge_seen[i])
      );
   end

endmodule

// File: tb/tb_mxc_pulse_shaper.sv
// Directed vector bench for the pulse shaper.
module tb_mxc_pulse_shaper;
   import mxc_pkg::*;

   logic           clk;
   logic           rst_n;
   logic [NCH-1:0] mxc_in;
   logic [NCH-1:0] clr_seen;
   logic [NCH-1:0] pulse_out;
   logic [NCH-1:0] busy;
   logic [NCH-1:0] edge_seen;

   int total;
   int bad;

   mxc_pulse_shaper_if cfg_if ();

   mxc_pulse_shaper dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mxc_in    (mxc_in),
      .cfg       (cfg_if),
      .clr_seen  (clr_seen),
      .pulse_out (pulse_out),
      .busy      (busy),
      .edge_seen (edge_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  mxc;
      logic [7:0]  clr;
      logic        wr;
      logic [2:0]  sel;
      logic [15:0] w;
      logic        en;
      logic        pol;
      logic [7:0]  e_pulse;
      logic [7:0]  e_busy;
      logic [7:0]  e_seen;
   } vec_t;

   vec_t vt[19];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   task automatic cfg_write(input logic [2:0] sel, input logic [15:0] w,
                            input logic en, input logic pol);
      cfg_if.cfg_wr    = 1'b1;
      cfg_if.cfg_sel   = sel;
      cfg_if.cfg_width = w;
      cfg_if.cfg_en    = en;
      cfg_if.cfg_pol   = pol;
      step();
      cfg_if.cfg_wr    = 1'b0;
   endtask

   function automatic vec_t mk(logic [7:0] mxc, logic [7:0] clr, logic wr,
                               logic [2:0] sel, logic [15:0] w, logic en,
                               logic pol, logic [7:0] ep, logic [7:0] eb,
                               logic [7:0] es);
      vec_t v;
      v.mxc = mxc; v.clr = clr; v.wr = wr; v.sel = sel; v.w = w;
      v.en = en; v.pol = pol; v.e_pulse = ep; v.e_busy = eb; v.e_seen = es;
      return v;
   endfunction

   initial begin
      int cnt;
      logic [9:0] rt_in;
      logic [9:0] rt_exp;

      total = 0;
      bad = 0;
      rst_n = 1'b0;
      mxc_in = '0;
      clr_seen = '0;
      cfg_if.cfg_wr = 1'b0;
      cfg_if.cfg_sel = '0;
      cfg_if.cfg_width = '0;
      cfg_if.cfg_en = 1'b0;
      cfg_if.cfg_pol = 1'b0;

      //       mxc   clr   wr  sel w       en pol  pulse busy  seen
      vt[0]  = mk(8'h01, 8'h00, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h01);
      vt[1]  = mk(8'h00, 8'h00, 1, 0, 16'd3, 1, 0, 8'h00, 8'h00, 8'h01);
      vt[2]  = mk(8'h01, 8'h00, 0, 0, 16'd0, 0, 0, 8'h01, 8'h01, 8'h01);
      vt[3]  = mk(8'h01, 8'h00, 0, 0, 16'd0, 0, 0, 8'h01, 8'h01, 8'h01);
      vt[4]  = mk(8'h01, 8'h00, 0, 0, 16'd0, 0, 0, 8'h01, 8'h01, 8'h01);
      vt[5]  = mk(8'h01, 8'h00, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h01);
      vt[6]  = mk(8'h00, 8'h01, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h00);
      vt[7]  = mk(8'h00, 8'h00, 1, 5, 16'd2, 1, 1, 8'h20, 8'h00, 8'h00);
      vt[8]  = mk(8'h20, 8'h00, 0, 0, 16'd0, 0, 0, 8'h00, 8'h20, 8'h20);
      vt[9]  = mk(8'h20, 8'h00, 0, 0, 16'd0, 0, 0, 8'h00, 8'h20, 8'h20);
      vt[10] = mk(8'h00, 8'h00, 0, 0, 16'd0, 0, 0, 8'h20, 8'h00, 8'h20);
      vt[11] = mk(8'h00, 8'h20, 1, 5, 16'd0, 1, 1, 8'h20, 8'h00, 8'h00);
      vt[12] = mk(8'h20, 8'h00, 0, 0, 16'd0, 0, 0, 8'h20, 8'h00, 8'h20);
      vt[13] = mk(8'h00, 8'h00, 1, 5, 16'd0, 0, 0, 8'h00, 8'h00, 8'h20);
      vt[14] = mk(8'h00, 8'h20, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h00);
      vt[15] = mk(8'h08, 8'h00, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h08);
      vt[16] = mk(8'h00, 8'h00, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h08);
      vt[17] = mk(8'h08, 8'h08, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h08);
      vt[18] = mk(8'h00, 8'h08, 0, 0, 16'd0, 0, 0, 8'h00, 8'h00, 8'h00);

      step();
      step();
      check("rst_pulse", int'(pulse_out), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_seen", int'(edge_seen), 0);
      rst_n = 1'b1;
      step();

      foreach (vt[k]) begin
         mxc_in = vt[k].mxc;
         clr_seen = vt[k].clr;
         cfg_if.cfg_wr = vt[k].wr;
         cfg_if.cfg_sel = vt[k].sel;
         cfg_if.cfg_width = vt[k].w;
         cfg_if.cfg_en = vt[k].en;
         cfg_if.cfg_pol = vt[k].pol;
         step();
         check($sformatf("vec%0d_pulse", k), int'(pulse_out), int'(vt[k].e_pulse));
         check($sformatf("vec%0d_busy", k), int'(busy), int'(vt[k].e_busy));
         check($sformatf("vec%0d_seen", k), int'(edge_seen), int'(vt[k].e_seen));
      end
      mxc_in = '0;
      clr_seen = '0;
      cfg_if.cfg_wr = 1'b0;

      // retrigger on ch2: edges at N and N+3
      cfg_write(3'd2, 16'd5, 1'b1, 1'b0);
      rt_in  = 10'b0000001011;
      rt_exp = 10'b0011111111;
      for (int i = 0; i < 10; i++) begin
         mxc_in[2] = rt_in[i];
         step();
         check($sformatf("retrig_c%0d", i), int'(pulse_out[2]), int'(rt_exp[i]));
      end
      mxc_in = '0;
      step();

      // ch1: width change mid-pulse only affects the next trigger
      cfg_write(3'd1, 16'd10, 1'b1, 1'b0);
      mxc_in[1] = 1'b1;
      step();
      cnt = int'(pulse_out[1]);
      mxc_in[1] = 1'b0;
      for (int i = 1; i < 20; i++) begin
         if (i == 3) begin
            cfg_if.cfg_wr = 1'b1;
            cfg_if.cfg_sel = 3'd1;
            cfg_if.cfg_width = 16'd2;
            cfg_if.cfg_en = 1'b1;
            cfg_if.cfg_pol = 1'b0;
         end else begin
            cfg_if.cfg_wr = 1'b0;
         end
         step();
         cnt += int'(pulse_out[1]);
      end
      cfg_if.cfg_wr = 1'b0;
      check("midw_old_len", cnt, 10);
      mxc_in[1] = 1'b1;
      step();
      cnt = int'(pulse_out[1]);
      mxc_in[1] = 1'b0;
      for (int i = 1; i < 10; i++) begin
         step();
         cnt += int'(pulse_out[1]);
      end
      check("midw_new_len", cnt, 2);

      // disable mid-pulse
      cfg_write(3'd1, 16'd10, 1'b1, 1'b0);
      mxc_in[1] = 1'b1;
      step();
      mxc_in[1] = 1'b0;
      step();
      step();
      check("dis_busy_before", int'(busy[1]), 1);
      cfg_write(3'd1, 16'd10, 1'b0, 1'b0);
      check("dis_busy_after", int'(busy[1]), 0);
      check("dis_pulse_after", int'(pulse_out[1]), 0);
      step();

      // maximum width on ch4
      cfg_write(3'd4, 16'hFFFF, 1'b1, 1'b0);
      mxc_in[4] = 1'b1;
      step();
      mxc_in[4] = 1'b0;
      cnt = 0;
      while (pulse_out[4] && cnt < 70000) begin
         cnt++;
         step();
      end
      check("maxw_len", cnt, 65535);

      // async reset mid-pulse, channel disabled afterwards
      mxc_in[4] = 1'b1;
      step();
      step();
      check("ar_pulse_before", int'(pulse_out[4]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_pulse", int'(pulse_out), 0);
      check("ar_busy", int'(busy), 0);
      check("ar_seen", int'(edge_seen), 0);
      step();
      rst_n = 1'b1;
      step();
      check("ar_post_pulse", int'(pulse_out), 0);
      check("ar_post_seen", int'(edge_seen), 8'h10);
      step();
      check("ar_post_busy", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
